// File: rtl/uart_cmd_bridge.sv
// -----------------------------------------------------------------------------
// uart_cmd_bridge
//
// Command responder sitting behind a UART byte-stream interface. It decodes
// host packets, turns each one into a single-word memory-mapped read or write,
// and streams the reply back to the transmit side. This gives a host PC a
// debug/load path into on-chip memory or CSR space.
//
// Packet format (all multi-byte fields little-endian, LSB byte first):
//   write : 8'h01, addr[addr_width_p/8 bytes], data[data_width_p/8 bytes]
//           reply ack_byte_p once the memory response arrives
//   read  : 8'h02, addr[addr_width_p/8 bytes]
//           reply data_width_p/8 read-data bytes, LSB first
//   other opcode or a line error : reply err_byte_p
//   packet stalls for timeout_p-1 idle cycles : dropped silently,
//           timeout_o pulses
//
// Ports:
//   clk_i, reset_n_i        clock, asynchronous active-low reset
//   rx_v_i, rx_i            received byte and its valid
//   rx_yumi_o               byte consumed this cycle (combinational)
//   rx_error_i              one-cycle frame/parity error pulse
//   tx_v_o, tx_o            reply byte and its valid
//   tx_ready_and_i          transmit side accepts the reply byte
//   mem_v_o, mem_w_o        request valid, 1=write / 0=read
//   mem_addr_o, mem_data_o  request address and write data
//   mem_ready_and_i         request accepted
//   mem_resp_v_i            response valid (reads and writes)
//   mem_resp_data_i         read data
//   mem_resp_yumi_o         response consumed
//   busy_o                  FSM is away from IDLE
//   timeout_o               one-cycle pulse when a packet is abandoned
//
// Parameter constraints: addr_width_p and data_width_p are multiples of 8,
// timeout_p >= 2.
// -----------------------------------------------------------------------------
module uart_cmd_bridge #(
    parameter int         addr_width_p = 16,
    parameter int         data_width_p = 32,
    parameter int         timeout_p    = 1000000,
    parameter logic [7:0] ack_byte_p   = 8'hA5,
    parameter logic [7:0] err_byte_p   = 8'hEE
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,

    input  logic                    rx_v_i,
    input  logic [7:0]              rx_i,
    output logic                    rx_yumi_o,
    input  logic                    rx_error_i,

    output logic                    tx_v_o,
    output logic [7:0]              tx_o,
    input  logic                    tx_ready_and_i,

    output logic                    mem_v_o,
    output logic                    mem_w_o,
    output logic [addr_width_p-1:0] mem_addr_o,
    output logic [data_width_p-1:0] mem_data_o,
    input  logic                    mem_ready_and_i,
    input  logic                    mem_resp_v_i,
    input  logic [data_width_p-1:0] mem_resp_data_i,
    output logic                    mem_resp_yumi_o,

    output logic                    busy_o,
    output logic                    timeout_o
);

    localparam int addr_bytes_lp = addr_width_p / 8;
    localparam int data_bytes_lp = data_width_p / 8;
    localparam int max_bytes_lp  = (addr_bytes_lp > data_bytes_lp) ? addr_bytes_lp : data_bytes_lp;
    localparam int cnt_w_lp      = (max_bytes_lp > 1) ? $clog2(max_bytes_lp) : 1;
    localparam int tmo_w_lp      = $clog2(timeout_p);

    localparam logic [cnt_w_lp-1:0] addr_last_lp = cnt_w_lp'(addr_bytes_lp - 1);
    localparam logic [cnt_w_lp-1:0] data_last_lp = cnt_w_lp'(data_bytes_lp - 1);
    localparam logic [tmo_w_lp-1:0] tmo_max_lp   = tmo_w_lp'(timeout_p - 1);
    // The counter reaches timeout_p-1 on the edge that ends the cycle in
    // which it reads timeout_p-2; that cycle carries the pulse and the exit.
    localparam logic [tmo_w_lp-1:0] tmo_fire_lp  = tmo_w_lp'(timeout_p - 2);

    localparam logic [7:0] op_write_lp = 8'h01;
    localparam logic [7:0] op_read_lp  = 8'h02;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        REQ,
        RESP,
        SEND_ACK,
        SEND_DATA,
        SEND_ERR
    } state_e;

    state_e                    state_r, state_n;
    logic [cnt_w_lp-1:0]       cnt_r;
    logic [tmo_w_lp-1:0]       tmo_r;
    logic                      wr_r;
    logic [addr_width_p-1:0]   addr_r;
    logic [data_width_p-1:0]   data_r;

    logic in_rx;      // states that consume received bytes
    logic in_pkt;     // mid-packet states covered by the timeout
    logic rx_take;
    logic tx_fire;
    logic addr_last;
    logic data_last;
    logic tmo_hit;

    assign in_rx     = (state_r == IDLE) || (state_r == ADDR) || (state_r == DATA);
    assign in_pkt    = (state_r == ADDR) || (state_r == DATA);
    assign rx_take   = in_rx && rx_v_i;
    assign tx_fire   = tx_v_o && tx_ready_and_i;
    assign addr_last = (cnt_r == addr_last_lp);
    assign data_last = (cnt_r == data_last_lp);
    // A line error outranks the timeout when both land in the same cycle.
    assign tmo_hit   = in_pkt && !rx_v_i && !rx_error_i && (tmo_r == tmo_fire_lp);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE: begin
                if (rx_error_i) begin
                    state_n = SEND_ERR;
                end else if (rx_v_i) begin
                    if ((rx_i == op_write_lp) || (rx_i == op_read_lp)) begin
                        state_n = ADDR;
                    end else begin
                        state_n = SEND_ERR;
                    end
                end
            end
            ADDR: begin
                if (rx_error_i) begin
                    state_n = SEND_ERR;
                end else if (rx_v_i) begin
                    if (addr_last) begin
                        state_n = wr_r ? DATA : REQ;
                    end
                end else if (tmo_hit) begin
                    state_n = IDLE;
                end
            end
            DATA: begin
                if (rx_error_i) begin
                    state_n = SEND_ERR;
                end else if (rx_v_i) begin
                    if (data_last) begin
                        state_n = REQ;
                    end
                end else if (tmo_hit) begin
                    state_n = IDLE;
                end
            end
            REQ: begin
                if (mem_ready_and_i) begin
                    state_n = RESP;
                end
            end
            RESP: begin
                if (mem_resp_v_i) begin
                    state_n = wr_r ? SEND_ACK : SEND_DATA;
                end
            end
            SEND_ACK, SEND_ERR: begin
                if (tx_ready_and_i) begin
                    state_n = IDLE;
                end
            end
            SEND_DATA: begin
                if (tx_ready_and_i && data_last) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: byte counter, timeout counter, opcode flag, addr/data regs
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_r  <= '0;
            tmo_r  <= '0;
            wr_r   <= 1'b0;
            addr_r <= '0;
            data_r <= '0;
        end else begin
            // Byte counter restarts on every state change so each field and
            // the reply stream all index from byte 0.
            if (state_n != state_r) begin
                cnt_r <= '0;
            end else if ((in_pkt && rx_v_i) || ((state_r == SEND_DATA) && tx_fire)) begin
                cnt_r <= cnt_r + cnt_w_lp'(1);
            end

            // Idle-gap counter: cleared by any consumed byte or state change,
            // saturates instead of wrapping.
            if ((state_n != state_r) || rx_take) begin
                tmo_r <= '0;
            end else if (in_pkt && (tmo_r != tmo_max_lp)) begin
                tmo_r <= tmo_r + tmo_w_lp'(1);
            end

            if ((state_r == IDLE) && rx_take && !rx_error_i) begin
                wr_r <= (rx_i == op_write_lp);
            end

            // Bytes arriving together with a line error are consumed but
            // never stored.
            if ((state_r == ADDR) && rx_take && !rx_error_i) begin
                for (int b = 0; b < addr_bytes_lp; b++) begin
                    if (cnt_r == cnt_w_lp'(b)) begin
                        addr_r[8*b +: 8] <= rx_i;
                    end
                end
            end

            // data_r holds write data on the way out and read data on the
            // way back; the two uses never overlap.
            if ((state_r == DATA) && rx_take && !rx_error_i) begin
                for (int b = 0; b < data_bytes_lp; b++) begin
                    if (cnt_r == cnt_w_lp'(b)) begin
                        data_r[8*b +: 8] <= rx_i;
                    end
                end
            end else if ((state_r == RESP) && mem_resp_v_i && !wr_r) begin
                data_r <= mem_resp_data_i;
            end
        end
    end

    assign mem_addr_o = addr_r;
    assign mem_data_o = data_r;

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        rx_yumi_o       = rx_take;
        busy_o          = (state_r != IDLE);
        mem_v_o         = (state_r == REQ);
        mem_w_o         = (state_r == REQ) && wr_r;
        mem_resp_yumi_o = (state_r == RESP) && mem_resp_v_i;
        timeout_o       = tmo_hit;
        tx_v_o          = 1'b0;
        tx_o            = 8'h00;
        case (state_r)
            SEND_ACK: begin
                tx_v_o = 1'b1;
                tx_o   = ack_byte_p;
            end
            SEND_ERR: begin
                tx_v_o = 1'b1;
                tx_o   = err_byte_p;
            end
            SEND_DATA: begin
                tx_v_o = 1'b1;
                for (int b = 0; b < data_bytes_lp; b++) begin
                    if (cnt_r == cnt_w_lp'(b)) begin
                        tx_o = data_r[8*b +: 8];
                    end
                end
            end
            default: begin
                tx_v_o = 1'b0;
                tx_o   = 8'h00;
            end
        endcase
    end

endmodule
